// File: rtl/mips16_pkg.sv
// Shared encodings for the 16-bit MIPS control and datapath:
// states, opcodes, ALU operations and ALU B-operand selects.
package mips16_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_RTYPE_EX = 4'd3,
        S_RTYPE_WB = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BRANCH   = 4'd10
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational R-type opcode to ALU operation map; non-R-type opcodes yield add.
module alu_op_decode
    import mips16_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM for the 16-bit MIPS datapath with a shared,
// ready-handshaked memory port and a retired-instruction counter.
module multicycle_control
    import mips16_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_e           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [2:0]       rtype_alu_op;
    state_e           boundary;

    alu_op_decode u_alu_op_decode (
        .opcode (opcode_q),
        .alu_op (rtype_alu_op)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            opcode_q      <= 4'd0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            instr_count_q <= instr_count_d;
        end
    end

    // run is only honoured here, after the last cycle of an instruction
    assign boundary = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <= PC + (imm << 2), ready for a possible branch
                alu_src_b = SRCB_BRANCH;
                if (is_rtype(opcode)) begin
                    state_d = S_RTYPE_EX;
                end else if (opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM_ADDR;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_d = S_BRANCH;
                end else begin
                    illegal = 1'b1;
                    state_d = boundary;
                end
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = rtype_alu_op;
                state_d   = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = boundary;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode_q == OP_LW)      state_d = S_MEM_RD;
                else if (opcode_q == OP_SW) state_d = S_MEM_WR;
                else                        state_d = S_ADDI_WB;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = boundary;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = boundary;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = boundary;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = 1'b1;
                pc_en      = (opcode_q == OP_BNE) ? ~zero : zero;
                instr_done = 1'b1;
                state_d    = boundary;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        opcode_d      = (state_q == S_DECODE) ? opcode : opcode_q;
        instr_count_d = instr_done ? instr_count_q + CNT_W'(1) : instr_count_q;
    end

    assign instr_count = instr_count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors push
// expected state/strobes/count; a negedge monitor pops and compares.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset, run, zero, mem_ready;
    logic [3:0]  opcode;
    logic        pc_en, pc_src, iord, mem_read, mem_write, ir_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        instr_done, illegal;
    logic [15:0] instr_count;
    logic [3:0]  state;
    logic [16:0] act;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [16:0] o;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // {pc_en,pc_src,iord,mem_read,mem_write,ir_write,reg_write,reg_dst,
    //  mem_to_reg,alu_src_a,alu_src_b,alu_op,instr_done,illegal}
    localparam logic [16:0] O_IDLE    = 17'b0_0_0_0_0_0_0_0_0_0_00_010_0_0;
    localparam logic [16:0] O_FETCH   = 17'b1_0_0_1_0_1_0_0_0_0_01_010_0_0;
    localparam logic [16:0] O_FSTALL  = 17'b0_0_0_1_0_0_0_0_0_0_01_010_0_0;
    localparam logic [16:0] O_DEC     = 17'b0_0_0_0_0_0_0_0_0_0_11_010_0_0;
    localparam logic [16:0] O_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_010_0_1;
    localparam logic [16:0] O_RT_SUB  = 17'b0_0_0_0_0_0_0_0_0_1_00_110_0_0;
    localparam logic [16:0] O_RT_AND  = 17'b0_0_0_0_0_0_0_0_0_1_00_000_0_0;
    localparam logic [16:0] O_RT_SLT  = 17'b0_0_0_0_0_0_0_0_0_1_00_111_0_0;
    localparam logic [16:0] O_RT_WB   = 17'b0_0_0_0_0_0_1_1_0_0_00_010_1_0;
    localparam logic [16:0] O_MADDR   = 17'b0_0_0_0_0_0_0_0_0_1_10_010_0_0;
    localparam logic [16:0] O_MRD     = 17'b0_0_1_1_0_0_0_0_0_0_00_010_0_0;
    localparam logic [16:0] O_MWB     = 17'b0_0_0_0_0_0_1_0_1_0_00_010_1_0;
    localparam logic [16:0] O_MWR_ST  = 17'b0_0_1_0_1_0_0_0_0_0_00_010_0_0;
    localparam logic [16:0] O_MWR_OK  = 17'b0_0_1_0_1_0_0_0_0_0_00_010_1_0;
    localparam logic [16:0] O_AWB     = 17'b0_0_0_0_0_0_1_0_0_0_00_010_1_0;
    localparam logic [16:0] O_BR_T    = 17'b1_1_0_0_0_0_0_0_0_1_00_110_1_0;
    localparam logic [16:0] O_BR_N    = 17'b0_1_0_0_0_0_0_0_0_1_00_110_1_0;

    multicycle_control #(.CNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .instr_count (instr_count),
        .state       (state)
    );

    always #5 clock = ~clock;

    assign act = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal};

    // Monitor: one expected record per cycle, checked mid-cycle
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL %s state got %0d expected %0d", e.tag, state, e.st);
            end
            checks++;
            if (act !== e.o) begin
                errors++;
                $display("FAIL %s outputs got %b expected %b", e.tag, act, e.o);
            end
            checks++;
            if (instr_count !== e.cnt) begin
                errors++;
                $display("FAIL %s instr_count got %0d expected %0d", e.tag, instr_count, e.cnt);
            end
        end
    end

    // Drive one cycle of inputs, queue what the DUT must show this cycle
    task automatic step(input string tag, input logic rst, input logic r,
                        input logic [3:0] op, input logic z, input logic rdy,
                        input logic [3:0] st, input logic [16:0] o, input logic [15:0] cnt);
        exp_t e;
        reset     = rst;
        run       = r;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        e.tag = tag;
        e.st  = st;
        e.o   = o;
        e.cnt = cnt;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; run = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clock);
        #1;
        step("reset",      1, 0, 4'h0, 0, 1, 4'd0, O_IDLE, 16'd0);
        step("idle_hold",  0, 0, 4'h0, 0, 1, 4'd0, O_IDLE, 16'd0);
        // SUB
        step("sub_idle",   0, 1, 4'h1, 0, 1, 4'd0,  O_IDLE,   16'd0);
        step("sub_fetch",  0, 1, 4'h1, 0, 1, 4'd1,  O_FETCH,  16'd0);
        step("sub_dec",    0, 1, 4'h1, 0, 1, 4'd2,  O_DEC,    16'd0);
        step("sub_ex",     0, 1, 4'h1, 0, 1, 4'd3,  O_RT_SUB, 16'd0);
        step("sub_wb",     0, 1, 4'h1, 0, 1, 4'd4,  O_RT_WB,  16'd0);
        // LW with two MEM_RD stall cycles
        step("lw_fetch",   0, 1, 4'h5, 0, 1, 4'd1,  O_FETCH,  16'd1);
        step("lw_dec",     0, 1, 4'h5, 0, 1, 4'd2,  O_DEC,    16'd1);
        step("lw_addr",    0, 1, 4'h5, 0, 1, 4'd5,  O_MADDR,  16'd1);
        step("lw_rd_st1",  0, 1, 4'h5, 0, 0, 4'd6,  O_MRD,    16'd1);
        step("lw_rd_st2",  0, 1, 4'h5, 0, 0, 4'd6,  O_MRD,    16'd1);
        step("lw_rd_ok",   0, 1, 4'h5, 0, 1, 4'd6,  O_MRD,    16'd1);
        step("lw_wb",      0, 1, 4'h5, 0, 1, 4'd7,  O_MWB,    16'd1);
        // BNE zero=0 taken, with one FETCH stall
        step("bne_fstall", 0, 1, 4'h9, 0, 0, 4'd1,  O_FSTALL, 16'd2);
        step("bne_fetch",  0, 1, 4'h9, 0, 1, 4'd1,  O_FETCH,  16'd2);
        step("bne_dec",    0, 1, 4'h9, 0, 1, 4'd2,  O_DEC,    16'd2);
        step("bne_br",     0, 1, 4'h9, 0, 1, 4'd10, O_BR_T,   16'd2);
        // BEQ zero=0 not taken, then zero=1 taken
        step("beq0_fetch", 0, 1, 4'h8, 0, 1, 4'd1,  O_FETCH,  16'd3);
        step("beq0_dec",   0, 1, 4'h8, 0, 1, 4'd2,  O_DEC,    16'd3);
        step("beq0_br",    0, 1, 4'h8, 0, 1, 4'd10, O_BR_N,   16'd3);
        step("beq1_fetch", 0, 1, 4'h8, 1, 1, 4'd1,  O_FETCH,  16'd4);
        step("beq1_dec",   0, 1, 4'h8, 1, 1, 4'd2,  O_DEC,    16'd4);
        step("beq1_br",    0, 1, 4'h8, 1, 1, 4'd10, O_BR_T,   16'd4);
        // Illegal 1100: pulse in DECODE, not counted, back to FETCH
        step("ill_fetch",  0, 1, 4'hC, 0, 1, 4'd1,  O_FETCH,   16'd5);
        step("ill_dec",    0, 1, 4'hC, 0, 1, 4'd2,  O_DEC_ILL, 16'd5);
        // AND: opcode input changes after DECODE, latched value must win
        step("and_fetch",  0, 1, 4'h2, 0, 1, 4'd1,  O_FETCH,  16'd5);
        step("and_dec",    0, 1, 4'h2, 0, 1, 4'd2,  O_DEC,    16'd5);
        step("and_ex",     0, 1, 4'h7, 0, 1, 4'd3,  O_RT_AND, 16'd5);
        step("and_wb",     0, 1, 4'h7, 0, 1, 4'd4,  O_RT_WB,  16'd5);
        // SLT
        step("slt_fetch",  0, 1, 4'h7, 0, 1, 4'd1,  O_FETCH,  16'd6);
        step("slt_dec",    0, 1, 4'h7, 0, 1, 4'd2,  O_DEC,    16'd6);
        step("slt_ex",     0, 1, 4'h7, 0, 1, 4'd3,  O_RT_SLT, 16'd6);
        step("slt_wb",     0, 1, 4'h7, 0, 1, 4'd4,  O_RT_WB,  16'd6);
        // SW with one MEM_WR stall
        step("sw_fetch",   0, 1, 4'h6, 0, 1, 4'd1,  O_FETCH,  16'd7);
        step("sw_dec",     0, 1, 4'h6, 0, 1, 4'd2,  O_DEC,    16'd7);
        step("sw_addr",    0, 1, 4'h6, 0, 1, 4'd5,  O_MADDR,  16'd7);
        step("sw_wr_st",   0, 1, 4'h6, 0, 0, 4'd8,  O_MWR_ST, 16'd7);
        step("sw_wr_ok",   0, 1, 4'h6, 0, 1, 4'd8,  O_MWR_OK, 16'd7);
        // ADDI with run dropped in DECODE: completes, then IDLE
        step("addi_fetch", 0, 1, 4'h4, 0, 1, 4'd1,  O_FETCH,  16'd8);
        step("addi_dec",   0, 0, 4'h4, 0, 1, 4'd2,  O_DEC,    16'd8);
        step("addi_addr",  0, 0, 4'h4, 0, 1, 4'd5,  O_MADDR,  16'd8);
        step("addi_wb",    0, 0, 4'h4, 0, 1, 4'd9,  O_AWB,    16'd8);
        step("post_idle1", 0, 0, 4'h4, 0, 1, 4'd0,  O_IDLE,   16'd9);
        step("post_idle2", 0, 0, 4'h4, 0, 1, 4'd0,  O_IDLE,   16'd9);
        // SW interrupted by async reset while stalled in MEM_WR
        step("rsw_idle",   0, 1, 4'h6, 0, 1, 4'd0,  O_IDLE,   16'd9);
        step("rsw_fetch",  0, 1, 4'h6, 0, 1, 4'd1,  O_FETCH,  16'd9);
        step("rsw_dec",    0, 1, 4'h6, 0, 1, 4'd2,  O_DEC,    16'd9);
        step("rsw_addr",   0, 1, 4'h6, 0, 1, 4'd5,  O_MADDR,  16'd9);
        step("rsw_wr_st",  0, 1, 4'h6, 0, 0, 4'd8,  O_MWR_ST, 16'd9);
        step("rsw_reset",  1, 1, 4'h6, 0, 0, 4'd0,  O_IDLE,   16'd0);
        step("rsw_after",  0, 0, 4'h6, 0, 1, 4'd0,  O_IDLE,   16'd0);
        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain queue size got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing FSM for the 16-bit MIPS datapath. It replaces the single-cycle combinational main control and splits each instruction into FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps. A single memory port is shared between instruction fetch and data access, so memory accesses stall on a ready handshake. The block drives every datapath mux, enable and ALU-op line, and counts retired instructions.

## Interface
- `CNT_W`, default 16, width of retired-instruction counter.
- `clock`  in  1  system clock, rising edge active.
- `reset`  in  1  asynchronous, active-high; forces IDLE.
- `run`  in  1  1 = execute; sampled only at instruction boundaries.
- `opcode`  in  4  IR[15:12] from instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes current read/write this cycle.
- `pc_en`  out  1  PC load enable.
- `pc_src`  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target).
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory request strobes.
- `ir_write`  out  1  instruction register load.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  1  write register: 0 = IR[9:8], 1 = IR[7:6].
- `mem_to_reg`  out  1  write data: 0 = ALUOut, 1 = memory data register.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = register B, 01 = const 4, 10 = sign-ext, 11 = sign-ext<<2.
- `alu_op`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each legal instruction.
- `illegal`  out  1  one-cycle pulse on decode of opcode 1010–1111.
- `instr_count`  out  CNT_W  retired legal instructions.
- `state`  out  4  current state encoding, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, RTYPE_EX=3, RTYPE_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, ADDI_WB=9, BRANCH=10.
- Any output not listed for a state is 0. The exception is `alu_op`, which defaults to 010.
- IDLE: all strobes 0. Go to FETCH when `run`=1.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `pc_src`=0, `ir_write` = `pc_en` = `mem_ready` (Mealy). Hold while `mem_ready`=0, else go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add; this precomputes the branch target into ALUOut. Next state by opcode:
  - 0000–0011 and 0111 → RTYPE_EX.
  - 0100, 0101, 0110 → MEM_ADDR.
  - 1000, 1001 → BRANCH.
  - Any other opcode → `illegal`=1, then go to the boundary.
- RTYPE_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from opcode (0000→010, 0001→110, 0010→000, 0011→001, 0111→111).
- RTYPE_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0; `instr_done`=1.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, add. Next: LW → MEM_RD, SW → MEM_WR, ADDI → ADDI_WB.
- MEM_RD: `mem_read`=1, `iord`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1; `instr_done`=1.
- MEM_WR: `mem_write`=1, `iord`=1. Hold until `mem_ready`. `instr_done` = `mem_ready`.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0; `instr_done`=1.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=1. `pc_en` = `zero` for BEQ, `~zero` for BNE. `instr_done`=1.
- Boundary: after the final cycle, go to FETCH if `run`=1, else IDLE. Deasserting `run` mid-instruction never aborts the instruction.
- `instr_count` increments on the clock edge ending each `instr_done` cycle. It wraps from all-ones to 0. Illegal opcodes are not counted.
- The opcode is latched into an internal register at DECODE, so it is used for every later step of the instruction.

## Timing
- Reset values: `state`=IDLE, `instr_count`=0, all strobes 0, `alu_op`=010.
- Reset is asynchronous. Asserted mid-operation (including during MEM_WR with `mem_write` high), all outputs drop in the same cycle with no completion pulse.
- Zero-wait cycle counts, FETCH through final cycle: R-type 4, ADDI 4, SW 4, LW 5, BEQ/BNE 3, illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. During a stall, the strobes stay stable and `pc_en`/`ir_write` stay 0.
- Outputs are Moore, except `pc_en`/`ir_write` in FETCH, `pc_en` in BRANCH, and `instr_done` in MEM_WR.

## Structure
- Package `mips16_pkg`: state encodings, opcode constants, `alu_op` constants, `alu_src_b` encodings. It is shared with the datapath.
- One sub-module: `alu_op_decode` (opcode → `alu_op`), purely combinational.

## Test plan
- Reset, `run`=1, `mem_ready`=1, opcode 0001: states 1,2,3,4. `alu_op`=110 in RTYPE_EX; `reg_write`=`reg_dst`=1 in cycle 4; `instr_count`=1.
- LW (0101) with `mem_ready` low for 2 cycles in MEM_RD: 7 cycles total. `mem_read`/`iord` held high throughout; `mem_to_reg`=1 in MEM_WB.
- BNE with `zero`=0 → `pc_en`=1, `pc_src`=1 in cycle 3. BEQ with `zero`=0 → `pc_en`=0. Both increment `instr_count`.
- Opcode 1100 → `illegal` pulse in cycle 2, no `reg_write`, `instr_count` unchanged, next state FETCH.
- `reset` asserted in MEM_WR while `mem_ready`=0 → `mem_write` low in the same cycle, `state`=0, `instr_count`=0.
- `run` dropped during DECODE of an ADDI → ADDI completes (`instr_done`), then IDLE. No FETCH until `run`=1.
